pipeline_ctrl: RTL and testbench

- Acts on the stall request from the load-use hazard detector. Also takes branch-taken from MEM, memory-busy and halt requests.
- Drives the enables and flushes for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers of the 5-stage FemtoRV32 pipeline.
- Control outputs are Mealy, so they take effect in the same cycle as the request. State holds the bubble mask, the memory-wait timeout, the sticky halt and the saturating performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 41 ++++
 rtl/sat_counter.sv | 24 ++
 rtl/pipeline_ctrl.sv | 123 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control block.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_BUBBLE = 2'd1,
        MEM_WAIT  = 2'd2,
        HALT      = 2'd3
    } state_e;

    // Per-cycle enable/flush bundle driven to the pipeline registers.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic pipe_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
    } ctrl_t;

    // Free-running pipeline: everything loads, nothing flushes.
    localparam ctrl_t CTRL_DEFAULT = '{
        pc_write:     1'b1,
        if_id_write:  1'b1,
        pipe_en:      1'b1,
        if_id_flush:  1'b0,
        id_ex_flush:  1'b0,
        ex_mem_flush: 1'b0
    };

    // Whole pipeline frozen, no flushes.
    localparam ctrl_t CTRL_FREEZE = '{
        pc_write:     1'b0,
        if_id_write:  1'b0,
        pipe_en:      1'b0,
        if_id_flush:  1'b0,
        id_ex_flush:  1'b0,
        ex_mem_flush: 1'b0
    };

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    // Count up on inc, holding at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/halt controller for the 5-stage FemtoRV32 pipeline.
// Enables and flushes are combinational (Mealy) so they act in the request
// cycle; halted and bus_error are registered.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_req,
    input  logic             branch_taken_mem,
    input  logic             mem_busy,
    input  logic             halt_req,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             pipe_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             halted,
    output logic             bus_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    state_e              state_q, state_d;
    logic   [WAIT_W-1:0] wait_q, wait_d;
    logic                halted_q, halted_d;
    logic                bus_err_q, bus_err_d;
    ctrl_t               ctrl_c;
    logic                flush_inc_c;
    logic                stall_inc_c;

    // State, wait counter and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            wait_q    <= '0;
            halted_q  <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            halted_q  <= halted_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Request prioritisation: halt > mem wait > branch flush > load-use bubble.
    always_comb begin
        ctrl_c      = CTRL_DEFAULT;
        state_d     = RUN;
        wait_d      = '0;
        bus_err_d   = bus_err_q;
        flush_inc_c = 1'b0;

        if (state_q == HALT) begin
            ctrl_c  = CTRL_FREEZE;
            state_d = HALT;
        end else if (halt_req) begin
            ctrl_c  = CTRL_FREEZE;
            state_d = HALT;
        end else if (mem_busy) begin
            // A pending branch stays asserted while MEM is frozen, so it is
            // picked up on the first cycle mem_busy drops.
            ctrl_c  = CTRL_FREEZE;
            state_d = MEM_WAIT;
            wait_d  = wait_q + WAIT_W'(1);
            if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
                bus_err_d = 1'b1;
                state_d   = HALT;
            end
        end else if (branch_taken_mem) begin
            ctrl_c.if_id_flush  = 1'b1;
            ctrl_c.id_ex_flush  = 1'b1;
            ctrl_c.ex_mem_flush = 1'b1;
            flush_inc_c         = 1'b1;
        end else if (stall_req && (state_q != LU_BUBBLE)) begin
            // The bubble state masks stall_req so a bubble is never doubled.
            ctrl_c.pc_write    = 1'b0;
            ctrl_c.if_id_write = 1'b0;
            ctrl_c.id_ex_flush = 1'b1;
            state_d            = LU_BUBBLE;
        end

        // Reset forces the free-running defaults regardless of state.
        if (rst) begin
            ctrl_c      = CTRL_DEFAULT;
            flush_inc_c = 1'b0;
        end

        halted_d    = (state_d == HALT);
        stall_inc_c = !rst && (state_q != HALT) && !ctrl_c.pc_write;
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc_c),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc_c),
        .count (flush_count)
    );

    assign pc_write     = ctrl_c.pc_write;
    assign if_id_write  = ctrl_c.if_id_write;
    assign pipe_en      = ctrl_c.pipe_en;
    assign if_id_flush  = ctrl_c.if_id_flush;
    assign id_ex_flush  = ctrl_c.id_ex_flush;
    assign ex_mem_flush = ctrl_c.ex_mem_flush;
    assign halted       = halted_q;
    assign bus_error    = bus_err_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table plus hand sequences,
// expected records queued on drive and popped when outputs are sampled.
module tb_pipeline_ctrl;

    localparam logic [5:0] DEF   = 6'b111_000;
    localparam logic [5:0] FRZ   = 6'b000_000;
    localparam logic [5:0] FLUSH = 6'b111_111;
    localparam logic [5:0] BUB   = 6'b001_010;

    // One cycle: inputs, expected Mealy controls for this cycle, and the
    // registered outputs expected as they stand entering this cycle.
    typedef struct {
        logic        rst;
        logic        stall;
        logic        branch;
        logic        busy;
        logic        halt;
        logic [5:0]  ctrl;
        logic        halted;
        logic        bus_err;
        logic [15:0] sc;
        logic [15:0] fc;
    } vec_t;

    logic clk = 1'b0;
    logic rst, stall_req, branch_taken_mem, mem_busy, halt_req;
    logic pc_write, if_id_write, pipe_en, if_id_flush, id_ex_flush, ex_mem_flush;
    logic halted, bus_error;
    logic [15:0] stall_cycles, flush_count;

    logic s_pc_write, s_if_id_write, s_pipe_en, s_if_id_flush, s_id_ex_flush, s_ex_mem_flush;
    logic s_halted, s_bus_error;
    logic [3:0] s_stall_cycles, s_flush_count;

    int n_checks = 0;
    int n_pass   = 0;
    vec_t sb_q[$];
    vec_t tbl[22];

    always #5 clk = ~clk;

    pipeline_ctrl #(.MAX_WAIT(15), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .stall_req(stall_req), .branch_taken_mem(branch_taken_mem),
        .mem_busy(mem_busy), .halt_req(halt_req), .pc_write(pc_write),
        .if_id_write(if_id_write), .pipe_en(pipe_en), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .halted(halted),
        .bus_error(bus_error), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    pipeline_ctrl #(.MAX_WAIT(31), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .stall_req(stall_req), .branch_taken_mem(branch_taken_mem),
        .mem_busy(mem_busy), .halt_req(halt_req), .pc_write(s_pc_write),
        .if_id_write(s_if_id_write), .pipe_en(s_pipe_en), .if_id_flush(s_if_id_flush),
        .id_ex_flush(s_id_ex_flush), .ex_mem_flush(s_ex_mem_flush), .halted(s_halted),
        .bus_error(s_bus_error), .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
    );

    function automatic vec_t mk(input logic r, input logic st, input logic br, input logic bz,
                                input logic hl, input logic [5:0] c, input logic h,
                                input logic be, input int sc, input int fc);
        vec_t v;
        v.rst = r; v.stall = st; v.branch = br; v.busy = bz; v.halt = hl;
        v.ctrl = c; v.halted = h; v.bus_err = be; v.sc = 16'(sc); v.fc = 16'(fc);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Called at a negedge: drive, queue expectation, sample, then advance one cycle.
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        rst = v.rst; stall_req = v.stall; branch_taken_mem = v.branch;
        mem_busy = v.busy; halt_req = v.halt;
        sb_q.push_back(v);
        #1;
        e = sb_q.pop_front();
        check({tag, ".ctrl"}, 32'({pc_write, if_id_write, pipe_en, if_id_flush,
                                   id_ex_flush, ex_mem_flush}), 32'(e.ctrl));
        check({tag, ".halted"}, 32'(halted), 32'(e.halted));
        check({tag, ".bus_error"}, 32'(bus_error), 32'(e.bus_err));
        check({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(e.sc));
        check({tag, ".flush_count"}, 32'(flush_count), 32'(e.fc));
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; stall_req = 1'b0; branch_taken_mem = 1'b0; mem_busy = 1'b0; halt_req = 1'b0;

        //             rst st br bz hl ctrl   h  be sc fc
        tbl[0]  = mk(1, 0, 0, 0, 0, DEF,   0, 0, 0, 0);  // reset state
        tbl[1]  = mk(1, 1, 0, 1, 1, DEF,   0, 0, 0, 0);  // reset overrides requests
        tbl[2]  = mk(0, 1, 0, 0, 0, BUB,   0, 0, 0, 0);  // load-use bubble
        tbl[3]  = mk(0, 1, 0, 0, 0, DEF,   0, 0, 1, 0);  // stall masked in bubble
        tbl[4]  = mk(0, 0, 0, 0, 0, DEF,   0, 0, 1, 0);
        tbl[5]  = mk(0, 1, 1, 0, 0, FLUSH, 0, 0, 1, 0);  // branch wins over stall
        tbl[6]  = mk(0, 0, 0, 0, 0, DEF,   0, 0, 1, 1);
        tbl[7]  = mk(0, 0, 0, 1, 0, FRZ,   0, 0, 1, 1);  // single wait cycle
        tbl[8]  = mk(0, 1, 0, 0, 0, BUB,   0, 0, 2, 1);  // stall taken from MEM_WAIT
        tbl[9]  = mk(0, 1, 0, 0, 0, DEF,   0, 0, 3, 1);
        tbl[10] = mk(1, 0, 0, 0, 0, DEF,   0, 0, 3, 1);  // reset clears counters
        tbl[11] = mk(0, 0, 1, 1, 0, FRZ,   0, 0, 0, 0);  // deferred branch during wait
        tbl[12] = mk(0, 0, 1, 1, 0, FRZ,   0, 0, 1, 0);
        tbl[13] = mk(0, 0, 1, 1, 0, FRZ,   0, 0, 2, 0);
        tbl[14] = mk(0, 0, 1, 0, 0, FLUSH, 0, 0, 3, 0);  // branch released
        tbl[15] = mk(0, 0, 0, 0, 0, DEF,   0, 0, 3, 1);
        tbl[16] = mk(0, 0, 0, 0, 1, FRZ,   0, 0, 3, 1);  // halt request
        tbl[17] = mk(0, 0, 0, 0, 0, FRZ,   1, 0, 4, 1);  // halted, frozen
        tbl[18] = mk(0, 1, 1, 0, 0, FRZ,   1, 0, 4, 1);  // requests ignored in HALT
        tbl[19] = mk(0, 0, 0, 1, 0, FRZ,   1, 0, 4, 1);
        tbl[20] = mk(1, 0, 0, 0, 0, DEF,   1, 0, 4, 1);  // reset exits HALT
        tbl[21] = mk(0, 0, 0, 0, 0, DEF,   0, 0, 0, 0);

        @(negedge clk);
        for (int i = 0; i < 22; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // 14 busy cycles is one short of the timeout; dropping busy recovers.
        apply(mk(1, 0, 0, 0, 0, DEF, 0, 0, 0, 0), "pre14.rst");
        for (int k = 0; k < 14; k++) apply(mk(0, 0, 0, 1, 0, FRZ, 0, 0, k, 0), $sformatf("wait14_%0d", k));
        apply(mk(0, 0, 0, 0, 0, DEF, 0, 0, 14, 0), "wait14.release");

        // 15 consecutive busy cycles trip the timeout.
        apply(mk(1, 0, 0, 0, 0, DEF, 0, 0, 14, 0), "pre15.rst");
        for (int k = 0; k < 15; k++) apply(mk(0, 0, 0, 1, 0, FRZ, 0, 0, k, 0), $sformatf("wait15_%0d", k));
        apply(mk(0, 0, 0, 0, 0, FRZ, 1, 1, 15, 0), "timeout.halt");
        apply(mk(0, 1, 1, 0, 0, FRZ, 1, 1, 15, 0), "timeout.sticky");
        apply(mk(1, 0, 0, 0, 0, DEF, 1, 1, 15, 0), "timeout.rst");
        apply(mk(0, 0, 0, 0, 0, DEF, 0, 0, 0, 0), "timeout.after");

        // Saturation on the 4-bit instance: 20 busy cycles, MAX_WAIT=31.
        rst = 1'b1; stall_req = 1'b0; branch_taken_mem = 1'b0; mem_busy = 1'b0; halt_req = 1'b0;
        @(negedge clk);
        rst = 1'b0; mem_busy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (k == 14) check("sat.at14", 32'(s_stall_cycles), 32'd14);
            if (k == 16) check("sat.at16", 32'(s_stall_cycles), 32'd15);
            @(negedge clk);
        end
        #1;
        check("sat.final", 32'(s_stall_cycles), 32'd15);
        check("sat.bus_error", 32'(s_bus_error), 32'd0);
        check("sat.pipe_en", 32'(s_pipe_en), 32'd0);
        mem_busy = 1'b0;
        @(negedge clk);
        #1;
        check("sat.resume", 32'({s_pc_write, s_pipe_en}), 32'b11);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
